counter_share_ctrl: RTL and testbench

COUNTER_SHARE_CTRL -- requirements
Module: counter_share_ctrl

---
 rtl/counter_ctrl_pkg.sv | 5 +
 rtl/rr_arb2.sv | 8 +
 rtl/counter_share_ctrl.sv | 65 ++++++
 tb/tb_counter_share_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared FSM state encoding and default counter width for counter_share_ctrl
package counter_ctrl_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; req[1:0], last (index last served) -> one-hot win[1:0]
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/counter_share_ctrl.sv
// counter_share_ctrl: arbitrates two requesters for an external counter; in clk/clear_n(clear)/req/len0/len1/hold/cnt_q, out cnt_clear/cnt_enable/gnt/done/busy
module counter_share_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             hold,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy
);
  state_t           state_q, state_d;
  logic             win_q, win_d, last_q, last_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [1:0]       win;
  rr_arb2 u_arb (.req(req), .last(last_q), .win(win));
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    len_d   = len_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: if (req != 2'b00) begin
        state_d = CLR;
        win_d   = (win == 2'b10);
        len_d   = (win == 2'b10) ? len1 : len0;
      end
      CLR:  state_d = (len_q != '0) ? RUN : DONE;
      RUN:  state_d = (cnt_q >= len_q) ? DONE : RUN;
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy       = (state_q != IDLE);
    gnt        = (clear && busy) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    done       = (state_q == DONE) ? gnt : 2'b00;
    cnt_clear  = clear && (state_q != CLR);
    cnt_enable = clear && (state_q == RUN) && !hold && (cnt_q < len_q);
  end
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      len_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb_counter_share_ctrl: directed self-checking bench for counter_share_ctrl with an external counter model
module tb_counter_share_ctrl;
  localparam int W = 4;
  logic         clk = 1'b0, clear = 1'b0, hold = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] len0 = '0, len1 = '0, cnt_q = '0;
  logic         cnt_clear, cnt_enable, busy;
  logic [1:0]   gnt, done;
  int           n_chk = 0, n_fail = 0;
  counter_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .req(req), .len0(len0), .len1(len1), .hold(hold),
    .cnt_q(cnt_q), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .gnt(gnt), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt_q <= !cnt_clear ? '0 : cnt_enable ? cnt_q + 1'b1 : cnt_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask
  task automatic go(input string tag, input logic [1:0] r, input logic [W-1:0] l0, input logic [W-1:0] l1,
                    input bit keep, input int hf, input int hn, input int ca, input int max, input bit seq,
                    input int ecyc, input logic [1:0] eg, input int eens);
    int cyc, ens;
    logic [1:0] g1, gd, dn;
    logic [W-1:0] prev;
    cyc = 0; ens = 0; g1 = 0; gd = 0; dn = 0; prev = 0;
    adv();
    req = r; len0 = l0; len1 = l1;
    samp();
    chk({tag, "_idle_gnt"}, gnt, 0);
    for (int i = 1; i <= max && cyc == 0; i++) begin
      adv();
      if (!keep) req = 2'b00;
      if (i == 2) begin len0 = '1; len1 = '1; end
      hold  = (i >= hf && i < hf + hn);
      clear = (i != ca);
      samp();
      if (i == 1) g1 = gnt;
      ens += int'(cnt_enable);
      chk({tag, "_gnt_onehot"}, $onehot0(gnt), 1);
      chk({tag, "_done_onehot"}, $onehot0(done), 1);
      if (hn > 0 && i > hf && i <= hf + hn) chk({tag, "_hold_frozen"}, cnt_q, prev);
      if (seq && i >= 2 && done == 2'b00) chk({tag, "_cnt_step"}, cnt_q, i - 2);
      if (i == ca) chk({tag, "_clr_outs"}, {gnt, done, cnt_enable, cnt_clear}, 0);
      prev = cnt_q;
      if (done != 2'b00) begin cyc = i; gd = gnt; dn = done; end
    end
    hold = 1'b0; clear = 1'b1;
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_first_gnt"}, g1, eg);
    chk({tag, "_done_bits"}, dn, ecyc != 0 ? eg : 2'b00);
    chk({tag, "_gnt_at_done"}, gd, ecyc != 0 ? eg : 2'b00);
    chk({tag, "_enables"}, ens, eens);
  endtask
  initial begin
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      adv();
      samp();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_en", cnt_enable, 0);
      chk("rst_cnt_clear", cnt_clear, 0);
    end
    adv();
    clear = 1'b1; req = 2'b00;
    samp();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt_clear", cnt_clear, 1);
    go("single",  2'b01, 4'd5, 4'd0, 1'b0, 0, 0, 0, 20, 1'b1, 8,  2'b01, 5);
    go("hold",    2'b10, 4'd0, 4'd4, 1'b0, 4, 3, 0, 20, 1'b0, 10, 2'b10, 4);
    go("tie1",    2'b11, 4'd2, 4'd3, 1'b1, 0, 0, 0, 20, 1'b0, 5,  2'b01, 2);
    go("tie2",    2'b11, 4'd2, 4'd3, 1'b1, 0, 0, 0, 20, 1'b0, 6,  2'b10, 3);
    go("tie3",    2'b11, 4'd2, 4'd3, 1'b1, 0, 0, 0, 20, 1'b0, 5,  2'b01, 2);
    go("zero",    2'b01, 4'd0, 4'd0, 1'b0, 0, 0, 0, 20, 1'b0, 2,  2'b01, 0);
    go("abort",   2'b01, 4'd9, 4'd0, 1'b0, 0, 0, 5, 14, 1'b0, 0,  2'b01, 3);
    go("tie_rst", 2'b11, 4'd1, 4'd1, 1'b0, 0, 0, 0, 20, 1'b0, 4,  2'b01, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
